// File: rtl/ysyx_23060096_inst_seq_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_inst_seq_if
//   Bundles the sequencer's IFU, decoder, LSU and retirement signals.
//   master : the sequencer (drives requests and write enables)
//   slave  : the surrounding core / testbench (IFU, decoder, LSU)
//
//   ifu_req    seq -> IFU  fetch request, level-held in FETCH
//   ifu_rvalid IFU -> seq  instruction word valid
//   ir_we      seq -> core instruction register write
//   dec_*      dec -> seq  decoder qualifiers from the registered IR
//   lsu_req    seq -> LSU  memory request, level-held in MEM
//   lsu_wen    seq -> LSU  store enable
//   lsu_done   LSU -> seq  memory access complete
//   pc_we      seq -> core PC update pulse
//   rf_we      seq -> core register file write
//   retire     seq -> core retired-instruction pulse
//   retire_cnt seq -> core retired-instruction count (32 bit)
//   halt       seq -> core sticky halt
//   err        seq -> core halt cause (2 bit)
// ---------------------------------------------------------------------------
interface ysyx_23060096_inst_seq_if;
    logic        ifu_req;
    logic        ifu_rvalid;
    logic        ir_we;
    logic        dec_regwr;
    logic        dec_memwr;
    logic        dec_memtoreg;
    logic        dec_ebreak;
    logic        dec_illegal;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_done;
    logic        pc_we;
    logic        rf_we;
    logic        retire;
    logic [31:0] retire_cnt;
    logic        halt;
    logic [1:0]  err;

    modport master (
        output ifu_req, ir_we, lsu_req, lsu_wen, pc_we, rf_we, retire,
               retire_cnt, halt, err,
        input  ifu_rvalid, dec_regwr, dec_memwr, dec_memtoreg, dec_ebreak,
               dec_illegal, lsu_done
    );

    modport slave (
        input  ifu_req, ir_we, lsu_req, lsu_wen, pc_we, rf_we, retire,
               retire_cnt, halt, err,
        output ifu_rvalid, dec_regwr, dec_memwr, dec_memtoreg, dec_ebreak,
               dec_illegal, lsu_done
    );
endinterface

// File: rtl/ysyx_23060096_inst_seq.sv
// ---------------------------------------------------------------------------
// ysyx_23060096_inst_seq
//   Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC
//   -> (MEM) -> WB, with HALT on ebreak, illegal instruction or a bus that
//   does not answer within TIMEOUT wait cycles. Gates IR/PC/RF writes and
//   counts retired instructions.
//
//   Parameters
//     TIMEOUT  max wait count in FETCH/MEM before a bus-error halt (1..255)
//   Ports
//     clk      core clock, rising edge
//     rst      asynchronous, active-high reset
//     bus      ysyx_23060096_inst_seq_if.master (IFU/decoder/LSU/retire)
// ---------------------------------------------------------------------------
module ysyx_23060096_inst_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                            clk,
    input logic                            rst,
    ysyx_23060096_inst_seq_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    localparam logic [1:0] ERR_EBREAK  = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_FETCH   = 2'd2;
    localparam logic [1:0] ERR_MEM     = 2'd3;
    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] retire_cnt_q;
    // Moore outputs are registered alongside the state so they come
    // straight from flops and drop to 0 with the asynchronous reset.
    logic        ifu_req_q, lsu_req_q, wb_q, halt_q;

    // Next-state, wait counter and halt cause.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                // A response in the timeout cycle still wins.
                if (bus.ifu_rvalid) begin
                    state_d = S_DECODE;
                end else if (wait_q == TIMEOUT_C) begin
                    state_d = S_HALT;
                    err_d   = ERR_FETCH;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                if (bus.dec_ebreak) begin
                    state_d = S_HALT;
                    err_d   = ERR_EBREAK;
                end else if (bus.dec_illegal) begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:   state_d = (bus.dec_memwr || bus.dec_memtoreg) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.lsu_done) begin
                    state_d = S_WB;
                end else if (wait_q == TIMEOUT_C) begin
                    state_d = S_HALT;
                    err_d   = ERR_MEM;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        // Fresh wait budget on every entry into a bus-wait state.
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            err_q        <= ERR_EBREAK;
            retire_cnt_q <= '0;
            ifu_req_q    <= 1'b0;
            lsu_req_q    <= 1'b0;
            wb_q         <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            ifu_req_q <= (state_d == S_FETCH);
            lsu_req_q <= (state_d == S_MEM);
            wb_q      <= (state_d == S_WB);
            halt_q    <= (state_d == S_HALT);
            if (state_q == S_WB) begin
                retire_cnt_q <= retire_cnt_q + 32'd1;   // wraps naturally
            end
        end
    end

    // Moore outputs.
    assign bus.ifu_req    = ifu_req_q;
    assign bus.lsu_req    = lsu_req_q;
    assign bus.pc_we      = wb_q;
    assign bus.retire     = wb_q;
    assign bus.halt       = halt_q;
    assign bus.err        = err_q;
    assign bus.retire_cnt = retire_cnt_q;

    // State-qualified write enables: one state flop AND one input each.
    assign bus.ir_we   = ifu_req_q & bus.ifu_rvalid;
    assign bus.lsu_wen = lsu_req_q & bus.dec_memwr;
    assign bus.rf_we   = wb_q & bus.dec_regwr;

endmodule

// File: tb/tb_ysyx_23060096_inst_seq.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060096_inst_seq
//   Scoreboard bench for the instruction sequencer: each issued instruction
//   pushes its expected write-back record, which is popped when the DUT
//   retires it. Halt causes, timeout boundaries, counter wrap and mid-MEM
//   reset are exercised directly.
// ---------------------------------------------------------------------------
module tb_ysyx_23060096_inst_seq;

    localparam int TIMEOUT = 4;
    localparam int BUDGET  = 64;

    typedef enum int {K_ALU, K_LOAD, K_STORE} kind_e;

    typedef struct {
        logic        rf_we;
        logic [31:0] cnt;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ysyx_23060096_inst_seq_if bus ();

    ysyx_23060096_inst_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        exp_q[$];
    logic [31:0] model_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are
    // sampled 2 units later, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_rvalid   = 1'b0;
        bus.dec_regwr    = 1'b0;
        bus.dec_memwr    = 1'b0;
        bus.dec_memtoreg = 1'b0;
        bus.dec_ebreak   = 1'b0;
        bus.dec_illegal  = 1'b0;
        bus.lsu_done     = 1'b0;
    endtask

    // Asserts reset, checks all outputs are 0 asynchronously, releases it,
    // checks the IDLE cycle and returns with the DUT in its first FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        check("rst_outputs", {22'd0, bus.ifu_req, bus.ir_we, bus.lsu_req, bus.lsu_wen,
                              bus.pc_we, bus.rf_we, bus.retire, bus.halt, bus.err}, 32'd0);
        check("rst_retire_cnt", bus.retire_cnt, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        model_cnt = '0;
        exp_q.delete();
        #2;
        check("idle_ifu_req", {31'd0, bus.ifu_req}, 32'd0);
        tick();
    endtask

    // Runs one instruction from its first FETCH cycle. fdel = cycles before
    // ifu_rvalid, mdel = cycles after MEM entry before lsu_done.
    task automatic run_instr(input kind_e k, input int fdel, input int mdel, input logic regwr);
        exp_t x;
        exp_t e;
        int   cyc;
        int   fcyc;
        int   mcyc;
        bit   done;
        logic memwr;
        logic mem;
        cyc   = 0;
        fcyc  = 0;
        mcyc  = 0;
        done  = 1'b0;
        memwr = (k == K_STORE);
        mem   = (k != K_ALU);
        e.rf_we = regwr;
        e.cnt   = model_cnt;
        e.lat   = 4 + fdel + (mem ? mdel + 1 : 0);
        exp_q.push_back(e);
        model_cnt = model_cnt + 32'd1;
        bus.dec_regwr    = regwr;
        bus.dec_memwr    = memwr;
        bus.dec_memtoreg = (k == K_LOAD);
        bus.dec_ebreak   = 1'b0;
        bus.dec_illegal  = 1'b0;
        while (!done && cyc < BUDGET) begin
            bus.ifu_rvalid = bus.ifu_req && (fcyc == fdel);
            bus.lsu_done   = bus.lsu_req && (mcyc == mdel);
            #2;
            cyc++;
            if (bus.ifu_req) begin
                check("ir_we", {31'd0, bus.ir_we}, {31'd0, (fcyc == fdel)});
                fcyc++;
            end
            if (bus.lsu_req) begin
                check("lsu_wen", {31'd0, bus.lsu_wen}, {31'd0, memwr});
                mcyc++;
            end
            if (bus.retire) begin
                x = exp_q.pop_front();
                check("pc_we", {31'd0, bus.pc_we}, 32'd1);
                check("rf_we", {31'd0, bus.rf_we}, {31'd0, x.rf_we});
                check("cnt_in_wb", bus.retire_cnt, x.cnt);
                check("latency", cyc, x.lat);
                check("mem_cycles", mcyc, mem ? mdel + 1 : 0);
                done = 1'b1;
            end else begin
                check("no_wb_enable", {30'd0, bus.pc_we, bus.rf_we}, 32'd0);
            end
            tick();
        end
        bus.ifu_rvalid = 1'b0;
        bus.lsu_done   = 1'b0;
        if (!done) check("retire_timeout", 32'd0, 32'd1);
        check("cnt_after", bus.retire_cnt, model_cnt);
        check("no_halt", {31'd0, bus.halt}, 32'd0);
    endtask

    // mode 0: ebreak+illegal, 1: illegal, 2: fetch never answers,
    // 3: load whose LSU never answers. want_wait = FETCH cycles (modes 0-2)
    // or MEM cycles (mode 3) seen before HALT.
    task automatic run_halt(input int mode, input logic [1:0] want_err, input int want_wait);
        int cyc;
        int fcyc;
        int mcyc;
        bit seen_wb;
        cyc     = 0;
        fcyc    = 0;
        mcyc    = 0;
        seen_wb = 1'b0;
        bus.dec_ebreak   = (mode == 0);
        bus.dec_illegal  = (mode <= 1);
        bus.dec_memtoreg = (mode == 3);
        bus.dec_regwr    = (mode == 3);
        bus.dec_memwr    = 1'b0;
        bus.lsu_done     = 1'b0;
        while (!bus.halt && cyc < BUDGET) begin
            bus.ifu_rvalid = bus.ifu_req && (mode != 2);
            #2;
            cyc++;
            if (bus.ifu_req) fcyc++;
            if (bus.lsu_req) mcyc++;
            if (bus.retire || bus.pc_we || bus.rf_we) seen_wb = 1'b1;
            tick();
        end
        bus.ifu_rvalid = 1'b0;
        check("halt", {31'd0, bus.halt}, 32'd1);
        check("err", {30'd0, bus.err}, {30'd0, want_err});
        check("no_retire", {31'd0, seen_wb}, 32'd0);
        check("wait_cycles", (mode == 3) ? mcyc : fcyc, want_wait);
        check("cnt_held", bus.retire_cnt, model_cnt);
        // HALT is sticky and ignores any late bus responses.
        repeat (3) begin
            bus.ifu_rvalid = 1'b1;
            bus.lsu_done   = 1'b1;
            #2;
            check("halt_quiet", {26'd0, bus.ifu_req, bus.lsu_req, bus.pc_we, bus.halt, bus.err},
                  {26'd0, 4'b0001, want_err});
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        int cyc;
        clear_inputs();
        #2;
        do_reset();
        check("first_fetch", {31'd0, bus.ifu_req}, 32'd1);

        // addi stream with same-cycle fetch responses
        repeat (10) run_instr(K_ALU, 0, 0, 1'b1);
        check("ten_retired", bus.retire_cnt, 32'd10);

        // store with lsu_done 3 cycles after MEM entry: 8 cycles total
        run_instr(K_STORE, 0, 3, 1'b0);
        run_instr(K_LOAD, 1, 0, 1'b1);
        run_instr(K_ALU, 2, 0, 1'b0);
        // responses landing exactly on the timeout cycle still win
        run_instr(K_ALU, TIMEOUT, 0, 1'b1);
        run_instr(K_LOAD, 0, TIMEOUT, 1'b1);

        // ebreak has priority over illegal
        run_halt(0, 2'd0, 1);

        do_reset();
        run_instr(K_ALU, 0, 0, 1'b1);
        run_halt(1, 2'd1, 1);

        // fetch timeout: TIMEOUT+1 FETCH cycles, then HALT
        do_reset();
        run_halt(2, 2'd2, TIMEOUT + 1);

        do_reset();
        run_instr(K_STORE, 0, 0, 1'b0);
        run_halt(3, 2'd3, TIMEOUT + 1);

        // retire counter wrap
        do_reset();
        dut.retire_cnt_q = 32'hFFFF_FFFF;
        model_cnt = 32'hFFFF_FFFF;
        run_instr(K_ALU, 0, 0, 1'b1);
        check("wrap_zero", bus.retire_cnt, 32'd0);
        check("wrap_no_err", {29'd0, bus.halt, bus.err}, 32'd0);

        // reset mid-MEM with lsu_req high
        do_reset();
        run_instr(K_ALU, 0, 0, 1'b1);
        run_instr(K_ALU, 0, 0, 1'b1);
        bus.dec_memtoreg = 1'b1;
        bus.dec_regwr    = 1'b1;
        cyc = 0;
        while (!bus.lsu_req && cyc < BUDGET) begin
            bus.ifu_rvalid = bus.ifu_req;
            cyc++;
            tick();
        end
        bus.ifu_rvalid = 1'b0;
        check("mem_reached", {31'd0, bus.lsu_req}, 32'd1);
        check("cnt_before_rst", bus.retire_cnt, 32'd2);
        #2;
        do_reset();
        check("fetch_after_rst", {31'd0, bus.ifu_req}, 32'd1);
        run_instr(K_ALU, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_23060096_inst_seq.md
# ysyx_23060096_inst_seq

Multi-cycle instruction sequencer for the NPC core. It steps each instruction through fetch, decode, execute, memory and write-back, and gates the architectural write enables (IR, PC, register file) that the decoder's RegWr/MemWr/MemtoReg only qualify. It handshakes with the IFU and LSU, detects bus timeouts, halts on ebreak or illegal instruction, and counts retired instructions.

## Interface
- TIMEOUT, 255: max wait cycles in FETCH or MEM before bus-error halt; range 1..255, 8-bit wait counter.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifu_req  out  1  fetch request, held high for the whole FETCH state
- ifu_rvalid  in  1  instruction word valid this cycle; sampled only in FETCH
- ir_we  out  1  instruction register write; = FETCH & ifu_rvalid
- dec_regwr  in  1  decoder RegWr
- dec_memwr  in  1  decoder MemWr (store)
- dec_memtoreg  in  1  decoder MemtoReg (load)
- dec_ebreak  in  1  decoded ebreak
- dec_illegal  in  1  no decode match
- lsu_req  out  1  memory request, held high for the whole MEM state
- lsu_wen  out  1  = MEM & dec_memwr
- lsu_done  in  1  memory access complete; sampled only in MEM
- pc_we  out  1  PC update pulse, high in WB
- rf_we  out  1  = WB & dec_regwr
- retire  out  1  one-cycle pulse per retired instruction, high in WB
- retire_cnt  out  32  retired-instruction count
- halt  out  1  sticky; high in HALT
- err  out  2  halt cause: 0 ebreak, 1 illegal, 2 fetch timeout, 3 mem timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is IDLE.
- Decoder inputs come from the registered IR. They are stable from DECODE through WB and ignored in every other state.
- Transitions:
  - IDLE -> FETCH, unconditionally, on the first edge after reset release.
  - FETCH -> DECODE when ifu_rvalid.
  - DECODE -> HALT with err=0 if dec_ebreak. Otherwise -> HALT with err=1 if dec_illegal. Otherwise -> EXEC. ebreak takes priority over illegal.
  - EXEC -> MEM if dec_memwr | dec_memtoreg, else -> WB.
  - MEM -> WB when lsu_done.
  - WB -> FETCH.
  - HALT stays in HALT until rst.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle spent in that state without its response.
  - At count == TIMEOUT with no response that cycle -> HALT, err=2 in FETCH, err=3 in MEM.
  - A response in the same cycle the count hits TIMEOUT wins: normal transition, no error.
- retire_cnt increments by 1 in each WB cycle and wraps 0xFFFF_FFFF -> 0.
- An instruction halted in DECODE is not retired: no pc_we, no rf_we, no count increment.
- err is registered on entry to HALT and holds its value.
- ifu_rvalid outside FETCH and lsu_done outside MEM are ignored and do not change the wait counter.

## Timing
- During and after reset, until the first edge: every output is 0, including retire_cnt=0, err=0 and halt=0.
- Outputs ifu_req, lsu_req, pc_we and retire are Moore (decoded from state). ir_we, lsu_wen and rf_we are state AND input only, with no other combinational paths.
- Latency:
  - ALU or branch instruction: 4 cycles with a same-cycle fetch response (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 + k cycles, where lsu_done arrives k cycles after MEM entry.
  - Each cycle ifu_rvalid is delayed adds one cycle.
- First ifu_req is high in the cycle after reset release.
- Reset asserted mid-instruction: immediate return to IDLE. All outputs drop to 0 asynchronously. retire_cnt clears. There is no partial write-back.
- Requests are level-held. The IFU and LSU must not assume a single-cycle pulse.

## Test plan
- Reset release, addi stream with same-cycle ifu_rvalid, dec_regwr=1 -> ifu_req at cycle 1, ir_we at cycle 1, pc_we=rf_we=retire at cycle 4. After 10 instructions, retire_cnt=10.
- Store, lsu_done 3 cycles after MEM entry -> lsu_req and lsu_wen high for 4 cycles, WB follows, rf_we=0, instruction total 8 cycles.
- dec_ebreak and dec_illegal both high in DECODE -> halt=1, err=0, retire_cnt unchanged, no further ifu_req.
- TIMEOUT=4, ifu_rvalid never asserted -> halt=1, err=2 after 5 FETCH cycles. Repeat with ifu_rvalid arriving on the 5th FETCH cycle -> no halt, DECODE follows.
- Preload retire_cnt to 0xFFFF_FFFF via 2^32-1 retires (or a forced value), one more retire -> retire_cnt=0, no error.
- rst pulsed during MEM with lsu_req high -> all outputs 0 within the reset cycle, retire_cnt=0, IDLE then FETCH after release.
